// File: rtl/debounce_pkg.sv
// Shared defaults and channel FSM encoding for the debounce bank.
package debounce_pkg;

  localparam int DEF_STABLE_CYCLES = 20000;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_SYNC_STAGES   = 2;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } chan_state_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounced channel: synchroniser, stability-check FSM, long-press counter
// and registered edge/hold pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic x,
  output logic y,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  chan_state_t            state;
  logic [SCW-1:0]         stable_cnt;
  logic [HCW-1:0]         hold_cnt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync       <= '0;
      state      <= ST_STABLE;
      stable_cnt <= '0;
      hold_cnt   <= '0;
      y          <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      hold       <= 1'b0;
    end else begin
      // The synchroniser samples even while disabled so no stale level is
      // presented when counting resumes.
      sync <= {sync[SYNC_STAGES-2:0], x};

      if (!en) begin
        rise <= 1'b0;
        fall <= 1'b0;
        hold <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;

        case (state)
          ST_STABLE: begin
            if (s != y) begin
              state      <= ST_CHECK;
              stable_cnt <= SCW'(1);
            end
          end
          ST_CHECK: begin
            if (s == y) begin
              state      <= ST_STABLE;
              stable_cnt <= '0;
            end else if (stable_cnt == SCW'(STABLE_CYCLES)) begin
              y          <= ~y;
              rise       <= ~y;
              fall       <= y;
              state      <= ST_STABLE;
              stable_cnt <= '0;
            end else begin
              stable_cnt <= stable_cnt + SCW'(1);
            end
          end
          default: begin
            state      <= ST_STABLE;
            stable_cnt <= '0;
          end
        endcase

        // Saturating at HOLD_CYCLES keeps the long-press pulse single-shot.
        if (y) begin
          if (hold_cnt < HCW'(HOLD_CYCLES)) begin
            hold_cnt <= hold_cnt + HCW'(1);
            hold     <= (hold_cnt == HCW'(HOLD_CYCLES - 1));
          end else begin
            hold <= 1'b0;
          end
        end else begin
          hold_cnt <= '0;
          hold     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of N independent debounced input channels sharing clock, reset and enable.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N             = 8,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [N-1:0] x,
  output logic [N-1:0] y,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] hold
);

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_chan (
      .clk  (clk),
      .rstn (rstn),
      .en   (en),
      .x    (x[gi]),
      .y    (y[gi]),
      .rise (rise[gi]),
      .fall (fall[gi]),
      .hold (hold[gi])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed scenarios plus randomized bouncing inputs, checked every cycle
// against a run-length reference model of the debouncer.
module tb_debounce_bank;

  localparam int N      = 4;
  localparam int STABLE = 4;
  localparam int HOLD   = 10;
  localparam int SYNC   = 2;

  logic         clk;
  logic         rstn;
  logic         en;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] hold;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: synchroniser pipeline, accepted level, length of
  // the current run of disagreeing samples, and cycles spent high.
  logic [N-1:0] m_pipe [SYNC];
  logic [N-1:0] m_y, m_rise, m_fall, m_hold;
  int           m_run [N];
  int           m_high [N];

  debounce_bank #(
    .N             (N),
    .STABLE_CYCLES (STABLE),
    .HOLD_CYCLES   (HOLD),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .x    (x),
    .y    (y),
    .rise (rise),
    .fall (fall),
    .hold (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int st = 0; st < SYNC; st++) m_pipe[st] = '0;
    m_y = '0; m_rise = '0; m_fall = '0; m_hold = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 0;
      m_high[i] = 0;
    end
  endtask

  // A level is accepted once the synchronised input has disagreed with the
  // current output on STABLE+1 consecutive enabled edges.
  task automatic model_step();
    logic [N-1:0] s_old;
    if (!rstn) begin
      model_reset();
      return;
    end
    s_old = m_pipe[SYNC-1];
    for (int st = SYNC - 1; st > 0; st--) m_pipe[st] = m_pipe[st-1];
    m_pipe[0] = x;
    m_rise = '0; m_fall = '0; m_hold = '0;
    if (!en) return;
    for (int i = 0; i < N; i++) begin
      if (m_y[i]) begin
        if (m_high[i] < HOLD) begin
          m_high[i]++;
          m_hold[i] = (m_high[i] == HOLD);
        end
      end else begin
        m_high[i] = 0;
      end
      if (s_old[i] != m_y[i]) begin
        m_run[i]++;
        if (m_run[i] == STABLE + 1) begin
          m_rise[i] = !m_y[i];
          m_fall[i] = m_y[i];
          m_y[i]    = !m_y[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y"},    y,    m_y);
    check({tag, ".rise"}, rise, m_rise);
    check({tag, ".fall"}, fall, m_fall);
    check({tag, ".hold"}, hold, m_hold);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    tick("in_rst");
    tick("in_rst");
    rstn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] target;
    rstn = 1'b0;
    en   = 1'b1;
    x    = '0;
    model_reset();
    #1;
    check_all("reset_state");
    tick("reset");
    rstn = 1'b1;
    tick("idle");

    // Clean single-channel edge.
    x = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick("clean");
      check("clean_rise0", rise, (k == 6) ? 4'b0001 : 4'b0000);
    end

    // Short glitch on channel 1 must be rejected.
    x = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) x[1] = 1'b0;
      tick("glitch");
      check("glitch_y1", {3'b000, y[1] | rise[1] | fall[1]}, 4'b0000);
    end

    // Long press on channel 2, then release.
    x[2] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick("press");
      check("press_rise2", {3'b000, rise[2]}, {3'b000, k == 6});
      check("press_hold2", {3'b000, hold[2]}, {3'b000, k == 16});
    end
    x[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick("release");
      check("release_fall2", {3'b000, fall[2]}, {3'b000, k == 6});
    end

    // Enable drop stretches the latency by the frozen cycles.
    x = '0;
    do_reset();
    x = 4'b1000;
    for (int k = 0; k < 14; k++) begin
      en = !(k >= 3 && k <= 7);
      tick("enable");
      check("enable_rise3", rise, (k == 11) ? 4'b1000 : 4'b0000);
    end
    en = 1'b1;

    // Simultaneous edges, then a reset in the middle of the check window.
    x = '0;
    do_reset();
    x = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick("simul");
      check("simul_rise", rise, (k == 6) ? 4'b1111 : 4'b0000);
    end
    x = '0;
    do_reset();
    x = 4'b1111;
    for (int k = 0; k < 4; k++) tick("midchk");
    do_reset();
    check("midchk_y0", y, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      tick("restart");
      check("restart_rise", rise, (k == 6) ? 4'b1111 : 4'b0000);
    end

    // Randomized bouncing inputs with occasional enable drops and resets.
    target = x;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) target[i] = ~target[i];
        x[i] = ($urandom_range(0, 9) == 0) ? ~target[i] : target[i];
      end
      en = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N, default 8, is the number of independent input channels (1..32).
REQ-002 Parameter STABLE_CYCLES, default 20000, is the clk cycles an input must hold a new level before it is accepted (>=1).
REQ-003 Parameter HOLD_CYCLES, default 50_000_000, is the clk cycles an accepted high level must persist before a long-press pulse (>=1).
REQ-004 Parameter SYNC_STAGES, default 2, is the synchroniser depth per channel (>=2).
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  global enable; 0 freezes all channel state.
REQ-008 x  input  N  raw asynchronous bouncing inputs.
REQ-009 y  output  N  debounced level per channel, registered.
REQ-010 rise  output  N  one-cycle pulse when y[i] goes 0->1.
REQ-011 fall  output  N  one-cycle pulse when y[i] goes 1->0.
REQ-012 hold  output  N  one-cycle long-press pulse per channel.

Function
REQ-013 Each channel SHALL pass x[i] through SYNC_STAGES flip-flops; s[i] denotes the last stage.
REQ-014 Each channel SHALL run a two-state FSM: STABLE (s==y) and CHECK (s!=y, counting).
REQ-015 STABLE->CHECK when s!=y; stable counter loads 1 on entry.
REQ-016 In CHECK, if s==y the counter SHALL clear and the FSM return to STABLE with y unchanged (glitch rejected).
REQ-017 In CHECK, when the counter reaches STABLE_CYCLES with s still !=y, y SHALL toggle on the next edge and the FSM return to STABLE.
REQ-018 Latency from a clean x edge to y change SHALL be exactly SYNC_STAGES+STABLE_CYCLES clk cycles.
REQ-019 rise[i]/fall[i] SHALL assert in the same cycle y[i] first shows its new value, for exactly one cycle; never both at once.
REQ-020 Hold counter SHALL count every cycle y[i]==1 and clear when y[i]==0; hold[i] pulses once when it reaches HOLD_CYCLES, then saturates (no repeat until y[i] falls and rises again).
REQ-021 Counter widths SHALL be $clog2(max+1) bits; no counter wraps.
REQ-022 en==0: synchronisers keep sampling; FSMs, counters and y hold; rise/fall/hold forced 0; resuming en continues from the held count.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.

Reset
REQ-024 rstn low SHALL asynchronously clear synchronisers, counters, FSM (STABLE), y, rise, fall, hold to 0.
REQ-025 A channel whose x is 1 at reset release SHALL raise y after SYNC_STAGES+STABLE_CYCLES cycles with a rise pulse.
REQ-026 Reset asserted mid-CHECK or mid-hold SHALL discard the partial count; no pulse on release.

Structure
REQ-027 A shared package debounce_pkg SHALL hold default constants (STABLE_CYCLES, HOLD_CYCLES, SYNC_STAGES) and the FSM state encoding.
REQ-028 One sub-module debounce_chan (single channel: synchroniser, FSM, both counters, pulse logic) SHALL be instantiated N times by a generate loop; the top holds no per-channel logic.

Verification (N=4, STABLE_CYCLES=4, HOLD_CYCLES=10, SYNC_STAGES=2)
REQ-029 x[0] 0->1 clean at cycle 0 -> y[0]=1 and rise[0]=1 at cycle 6 only; other channels quiet.
REQ-030 x[1] pulses high for 3 cycles then low -> y[1] stays 0, no rise/fall.
REQ-031 x[2] held 1 for 20 cycles -> rise[2] at cycle 6, hold[2] single pulse 10 cycles after y[2] rose, no second pulse; x[2] low -> fall[2] 6 cycles later.
REQ-032 x[3] 0->1, en dropped for 5 cycles at cycle 3 -> y[3] rises at cycle 11, pulses suppressed while en=0.
REQ-033 All x 0->1 simultaneously -> y=4'b1111 and rise=4'b1111 in the same cycle; rstn pulsed mid-CHECK -> all outputs 0, count restarts after release.
